// File: rtl/exu_scu_csr_pkg.sv
// Shared constants for the system control unit: operation encodings, CSR
// addresses, exception cause codes, mstatus bit positions, the latched
// request record and the CSR read-modify-write helper.
package exu_scu_csr_pkg;

    // Operation encodings on i_op
    localparam logic [2:0] OP_RW     = 3'd0;
    localparam logic [2:0] OP_RS     = 3'd1;
    localparam logic [2:0] OP_RC     = 3'd2;
    localparam logic [2:0] OP_ECALL  = 3'd4;
    localparam logic [2:0] OP_EBREAK = 3'd5;
    localparam logic [2:0] OP_MRET   = 3'd6;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    // Synchronous exception cause codes
    localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
    localparam logic [4:0] CAUSE_BREAK   = 5'd3;
    localparam logic [4:0] CAUSE_ECALL   = 5'd11;

    // mstatus bit positions
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // Everything captured from the offered instruction at accept time
    typedef struct packed {
        logic [2:0]  op;
        logic        no_write;   // RS/RC with x0 / zimm==0
        logic [11:0] addr;
        logic [31:0] operand;
        logic [31:0] pc;
        logic [31:0] mip;        // snapshot of the interrupt lines, CSR-aligned
        logic        irq_take;   // interrupt pre-empts this instruction
        logic [4:0]  irq_code;
    } req_t;

    // New CSR value for the read-modify-write forms
    function automatic logic [31:0] csr_wval(input logic [2:0] op,
                                             input logic [31:0] old,
                                             input logic [31:0] operand);
        case (op)
            OP_RS:   csr_wval = old | operand;
            OP_RC:   csr_wval = old & ~operand;
            default: csr_wval = operand;
        endcase
    endfunction

endpackage

// File: rtl/exu_scu_csr_irq_pick.sv
// Priority encoder for already-masked interrupt lines: the lowest pending
// line wins and is reported as its mcause code 16+k.
module scu_irq_pick #(
    parameter int IRQ_NUM = 4
) (
    input  logic [IRQ_NUM-1:0] pending,
    output logic               any,
    output logic [4:0]         code
);

    // Scan from the top down so the lowest set index is the last to assign
    always_comb begin
        any  = |pending;
        code = 5'd0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (pending[i]) code = 5'(16 + i);
        end
    end

endmodule

// File: rtl/exu_scu_csr.sv
// Machine-mode CSR file and trap sequencer. An accepted instruction is
// latched in IDLE and resolved in the single RESP cycle: CSR access with
// writeback, trap entry, or MRET, the latter two issuing a pipeline flush.
module exu_scu_csr
    import exu_scu_csr_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int          IRQ_NUM   = 4,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter int          VECTORED  = 1
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [2:0]         i_op,
    input  logic               i_imm_sel,
    input  logic [XLEN-1:0]    i_rs1_data,
    input  logic [4:0]         i_zimm,
    input  logic [4:0]         i_rs1_idx,
    input  logic [11:0]        i_csr_addr,
    input  logic [XLEN-1:0]    i_pc,
    input  logic [IRQ_NUM-1:0] i_irq,
    output logic               o_rdwen,
    output logic [XLEN-1:0]    o_wdata,
    output logic               o_flush,
    output logic [XLEN-1:0]    o_flush_pc
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    logic [0:0]         state_reg;
    req_t               req_reg;
    logic               mie_bit_reg, mpie_bit_reg;
    logic [IRQ_NUM-1:0] mie_reg;
    logic [XLEN-1:0]    mtvec_reg, mscratch_reg, mepc_reg, mcause_reg;
    logic [63:0]        mcycle_reg, mcycle_next;

    logic               accept, resp;
    logic [IRQ_NUM-1:0] pend_vec;
    logic               irq_any;
    logic [4:0]         irq_code;
    logic [XLEN-1:0]    mip_in, mstatus_val, mie_val, csr_old, csr_new;
    logic               csr_known, csr_legal, is_trap, is_int, is_mret, csr_wr;
    logic [4:0]         cause_code;
    logic [XLEN-1:0]    trap_base, trap_pc;

    assign accept   = i_valid & o_ready;
    assign resp     = (state_reg == ST_RESP);
    assign pend_vec = i_irq & mie_reg & {IRQ_NUM{mie_bit_reg}};

    scu_irq_pick #(.IRQ_NUM(IRQ_NUM)) u_irq_pick (
        .pending (pend_vec),
        .any     (irq_any),
        .code    (irq_code)
    );

    // CSR-aligned views of the sparse registers
    always_comb begin
        mip_in                    = '0;
        mip_in[16 +: IRQ_NUM]     = i_irq;
        mie_val                   = '0;
        mie_val[16 +: IRQ_NUM]    = mie_reg;
        mstatus_val               = '0;
        mstatus_val[MSTATUS_MIE]  = mie_bit_reg;
        mstatus_val[MSTATUS_MPIE] = mpie_bit_reg;
    end

    // FSM and capture of the offered instruction plus interrupt decision
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg <= ST_IDLE;
            req_reg   <= '0;
        end else if (accept) begin
            state_reg        <= ST_RESP;
            req_reg.op       <= i_op;
            req_reg.no_write <= (i_op != OP_RW) &&
                                (i_imm_sel ? (i_zimm == 5'd0) : (i_rs1_idx == 5'd0));
            req_reg.addr     <= i_csr_addr;
            req_reg.operand  <= i_imm_sel ? {27'd0, i_zimm} : i_rs1_data;
            req_reg.pc       <= i_pc;
            req_reg.mip      <= mip_in;
            req_reg.irq_take <= irq_any;
            req_reg.irq_code <= irq_code;
        end else begin
            state_reg <= ST_IDLE;
        end
    end

    // CSR read mux; unknown addresses are flagged for the illegal check
    always_comb begin
        csr_known = 1'b1;
        csr_old   = '0;
        case (req_reg.addr)
            CSR_MSTATUS:  csr_old = mstatus_val;
            CSR_MIE:      csr_old = mie_val;
            CSR_MTVEC:    csr_old = mtvec_reg;
            CSR_MSCRATCH: csr_old = mscratch_reg;
            CSR_MEPC:     csr_old = mepc_reg;
            CSR_MCAUSE:   csr_old = mcause_reg;
            CSR_MIP:      csr_old = req_reg.mip;
            CSR_MCYCLE:   csr_old = mcycle_reg[31:0];
            CSR_MCYCLEH:  csr_old = mcycle_reg[63:32];
            CSR_MHARTID:  csr_old = '0;
            default:      csr_known = 1'b0;
        endcase
    end

    // Resolve the latched request; a taken interrupt overrides the opcode
    always_comb begin
        is_trap    = 1'b0;
        is_int     = 1'b0;
        is_mret    = 1'b0;
        csr_legal  = 1'b0;
        cause_code = 5'd0;
        if (req_reg.irq_take) begin
            is_trap    = 1'b1;
            is_int     = 1'b1;
            cause_code = req_reg.irq_code;
        end else begin
            case (req_reg.op)
                OP_RW, OP_RS, OP_RC: begin
                    if (csr_known && !(req_reg.addr == CSR_MHARTID && !req_reg.no_write)) begin
                        csr_legal = 1'b1;
                    end else begin
                        is_trap    = 1'b1;
                        cause_code = CAUSE_ILLEGAL;
                    end
                end
                OP_ECALL:  begin is_trap = 1'b1; cause_code = CAUSE_ECALL; end
                OP_EBREAK: begin is_trap = 1'b1; cause_code = CAUSE_BREAK; end
                OP_MRET:   is_mret = 1'b1;
                default:   begin is_trap = 1'b1; cause_code = CAUSE_ILLEGAL; end
            endcase
        end
    end

    assign csr_new   = csr_wval(req_reg.op, csr_old, req_reg.operand);
    assign csr_wr    = resp & csr_legal & ~req_reg.no_write;
    assign trap_base = {mtvec_reg[XLEN-1:2], 2'b00};
    assign trap_pc   = (is_int && (VECTORED != 0) && mtvec_reg[0]) ?
                       trap_base + {{(XLEN-7){1'b0}}, cause_code, 2'b00} : trap_base;

    assign o_ready    = (state_reg == ST_IDLE);
    assign o_rdwen    = resp & csr_legal;
    assign o_wdata    = o_rdwen ? csr_old : '0;
    assign o_flush    = resp & (is_trap | is_mret);
    assign o_flush_pc = !o_flush ? '0 : (is_mret ? mepc_reg : trap_pc);

    // Architectural CSRs: trap entry, MRET, or a software write in RESP
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mie_bit_reg  <= 1'b0;
            mpie_bit_reg <= 1'b0;
            mie_reg      <= '0;
            mtvec_reg    <= MTVEC_RST;
            mscratch_reg <= '0;
            mepc_reg     <= '0;
            mcause_reg   <= '0;
        end else if (resp && is_trap) begin
            mepc_reg     <= {req_reg.pc[XLEN-1:2], 2'b00};
            mcause_reg   <= {is_int, {(XLEN-6){1'b0}}, cause_code};
            mpie_bit_reg <= mie_bit_reg;
            mie_bit_reg  <= 1'b0;
        end else if (resp && is_mret) begin
            mie_bit_reg  <= mpie_bit_reg;
            mpie_bit_reg <= 1'b1;
        end else if (csr_wr) begin
            case (req_reg.addr)
                CSR_MSTATUS: begin
                    mie_bit_reg  <= csr_new[MSTATUS_MIE];
                    mpie_bit_reg <= csr_new[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_reg      <= csr_new[16 +: IRQ_NUM];
                CSR_MTVEC:    mtvec_reg    <= {csr_new[XLEN-1:2], 1'b0,
                                               (VECTORED != 0) & csr_new[0]};
                CSR_MSCRATCH: mscratch_reg <= csr_new;
                CSR_MEPC:     mepc_reg     <= csr_new;
                CSR_MCAUSE:   mcause_reg   <= csr_new;
                default:      ;
            endcase
        end
    end

    // Free-running cycle counter; a written half is held instead of counted
    always_comb begin
        mcycle_next = mcycle_reg + 64'd1;
        if (csr_wr && req_reg.addr == CSR_MCYCLE) begin
            mcycle_next = {mcycle_reg[63:32], csr_new};
        end
        if (csr_wr && req_reg.addr == CSR_MCYCLEH) begin
            mcycle_next[63:32] = csr_new;
        end
    end

    // Counter register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) mcycle_reg <= '0;
        else         mcycle_reg <= mcycle_next;
    end

endmodule

// File: tb/tb_exu_scu_csr.sv
// Directed bench for exu_scu_csr: a vector table for single-operation
// behaviour plus hand sequences for interrupts, counter wrap and reset.
module tb_exu_scu_csr;

    localparam logic [2:0] RW = 3'd0, RS = 3'd1, RC = 3'd2, EC = 3'd4, EB = 3'd5, MR = 3'd6;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [2:0]  op = 3'd0;
    logic        imm_sel = 1'b0;
    logic [31:0] rs1_data = 32'd0;
    logic [4:0]  zimm = 5'd0;
    logic [4:0]  rs1_idx = 5'd0;
    logic [11:0] csr_addr = 12'd0;
    logic [31:0] pc = 32'd0;
    logic [3:0]  irq = 4'd0;
    logic        rdwen, flush;
    logic [31:0] wdata, flush_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exu_scu_csr dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_valid    (valid),
        .o_ready    (ready),
        .i_op       (op),
        .i_imm_sel  (imm_sel),
        .i_rs1_data (rs1_data),
        .i_zimm     (zimm),
        .i_rs1_idx  (rs1_idx),
        .i_csr_addr (csr_addr),
        .i_pc       (pc),
        .i_irq      (irq),
        .o_rdwen    (rdwen),
        .o_wdata    (wdata),
        .o_flush    (flush),
        .o_flush_pc (flush_pc)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic        imm;
        logic [31:0] rs1;
        logic [4:0]  zimm;
        logic [4:0]  idx;
        logic [11:0] addr;
        logic [31:0] pc;
        logic        rdwen;
        logic [31:0] wdata;
        logic        flush;
        logic [31:0] fpc;
    } vec_t;

    vec_t vecs[$];

    logic        g_rdwen, g_flush;
    logic [31:0] g_wdata, g_fpc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", name, got, exp);
        end
    endtask

    // Offer one instruction, wait for acceptance, sample the RESP outputs
    task automatic run_op(input logic [2:0] o, input logic im, input logic [31:0] r,
                          input logic [4:0] z, input logic [4:0] ix,
                          input logic [11:0] a, input logic [31:0] p);
        int n;
        @(negedge clk);
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got=0 exp=1");
        end
        op = o; imm_sel = im; rs1_data = r; zimm = z; rs1_idx = ix; csr_addr = a; pc = p;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        g_rdwen = rdwen; g_wdata = wdata; g_flush = flush; g_fpc = flush_pc;
        $display("op=%0d addr=%03h pc=%08h -> rdwen=%0b wdata=%08h flush=%0b fpc=%08h",
                 o, a, p, g_rdwen, g_wdata, g_flush, g_fpc);
    endtask

    // Read a CSR with RS x0 and compare the returned value
    task automatic rd_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
        run_op(RS, 1'b0, 32'd0, 5'd0, 5'd0, a, 32'h0);
        chk({name, "_rdwen"}, {31'd0, g_rdwen}, 32'd1);
        chk(name, g_wdata, exp);
    endtask

    // Expect a redirect with no writeback
    task automatic exp_flush(input string name, input logic [31:0] fpc);
        chk({name, "_flush"}, {31'd0, g_flush}, 32'd1);
        chk({name, "_rdwen"}, {31'd0, g_rdwen}, 32'd0);
        chk({name, "_fpc"}, g_fpc, fpc);
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic im, input logic [31:0] r,
                                input logic [4:0] z, input logic [4:0] ix, input logic [11:0] a,
                                input logic [31:0] p, input logic erd, input logic [31:0] ewd,
                                input logic efl, input logic [31:0] efp);
        mk = '{o, im, r, z, ix, a, p, erd, ewd, efl, efp};
    endfunction

    initial begin
        // Single-operation vectors, applied back to back from reset state
        vecs.push_back(mk(RW, 0, 32'hDEAD_BEEF, 0, 5, 12'h340, 0, 1, 32'h0, 0, 0));
        vecs.push_back(mk(RS, 0, 32'h0000_FFFF, 0, 0, 12'h340, 0, 1, 32'hDEAD_BEEF, 0, 0));
        vecs.push_back(mk(RS, 0, 32'h0, 0, 0, 12'h340, 0, 1, 32'hDEAD_BEEF, 0, 0));
        vecs.push_back(mk(RW, 0, 32'hF0, 0, 6, 12'h340, 0, 1, 32'hDEAD_BEEF, 0, 0));
        vecs.push_back(mk(RC, 1, 32'hFFFF_FFFF, 5'h10, 3, 12'h340, 0, 1, 32'hF0, 0, 0));
        vecs.push_back(mk(RS, 1, 32'hFFFF_FFFF, 5'h00, 3, 12'h340, 0, 1, 32'hE0, 0, 0));
        vecs.push_back(mk(RS, 0, 32'h0, 0, 0, 12'h340, 0, 1, 32'hE0, 0, 0));
        vecs.push_back(mk(RS, 1, 32'h0, 5'h03, 0, 12'h340, 0, 1, 32'hE0, 0, 0));
        vecs.push_back(mk(RS, 0, 32'h0, 0, 0, 12'h340, 0, 1, 32'hE3, 0, 0));
        vecs.push_back(mk(RW, 0, 32'h400, 0, 1, 12'h305, 0, 1, 32'h0, 0, 0));
        vecs.push_back(mk(EC, 0, 32'h0, 0, 0, 12'h000, 32'h80, 0, 0, 1, 32'h400));
        vecs.push_back(mk(RS, 0, 32'h0, 0, 0, 12'h342, 0, 1, 32'd11, 0, 0));
        vecs.push_back(mk(RS, 0, 32'h0, 0, 0, 12'h341, 0, 1, 32'h80, 0, 0));
        vecs.push_back(mk(EB, 0, 32'h0, 0, 0, 12'h000, 32'h1234, 0, 0, 1, 32'h400));
        vecs.push_back(mk(RS, 0, 32'h0, 0, 0, 12'h342, 0, 1, 32'd3, 0, 0));
        vecs.push_back(mk(RS, 0, 32'h0, 0, 0, 12'h341, 0, 1, 32'h1234, 0, 0));
        vecs.push_back(mk(RW, 0, 32'h1, 0, 1, 12'hF14, 32'h82, 0, 0, 1, 32'h400));
        vecs.push_back(mk(RS, 0, 32'h0, 0, 0, 12'h342, 0, 1, 32'd2, 0, 0));
        vecs.push_back(mk(RS, 0, 32'h0, 0, 0, 12'h341, 0, 1, 32'h80, 0, 0));
        vecs.push_back(mk(RS, 0, 32'h0, 0, 0, 12'hF14, 0, 1, 32'h0, 0, 0));
        vecs.push_back(mk(RS, 0, 32'h0, 0, 0, 12'h7C0, 32'h90, 0, 0, 1, 32'h400));
        vecs.push_back(mk(RS, 0, 32'h0, 0, 0, 12'h341, 0, 1, 32'h90, 0, 0));
        vecs.push_back(mk(3'd3, 0, 32'h0, 0, 0, 12'h340, 32'h90, 0, 0, 1, 32'h400));
        vecs.push_back(mk(3'd7, 0, 32'h0, 0, 0, 12'h340, 32'h90, 0, 0, 1, 32'h400));
        vecs.push_back(mk(RS, 0, 32'h0, 0, 0, 12'h342, 0, 1, 32'd2, 0, 0));
        vecs.push_back(mk(RS, 0, 32'h0, 0, 0, 12'h340, 0, 1, 32'hE3, 0, 0));
        vecs.push_back(mk(RW, 0, 32'hFFFF_FFFF, 0, 1, 12'h344, 0, 1, 32'h0, 0, 0));
        vecs.push_back(mk(MR, 0, 32'h0, 0, 0, 12'h000, 0, 0, 0, 1, 32'h90));
        vecs.push_back(mk(RS, 0, 32'h0, 0, 0, 12'h300, 0, 1, 32'h80, 0, 0));
        vecs.push_back(mk(RW, 0, 32'hFFFF_FFFF, 0, 1, 12'h300, 0, 1, 32'h80, 0, 0));
        vecs.push_back(mk(RW, 0, 32'h0, 0, 1, 12'h300, 0, 1, 32'h88, 0, 0));
        vecs.push_back(mk(RW, 0, 32'hFFFF_FFFF, 0, 1, 12'h304, 0, 1, 32'h0, 0, 0));
        vecs.push_back(mk(RW, 0, 32'h0, 0, 1, 12'h304, 0, 1, 32'h000F_0000, 0, 0));
        vecs.push_back(mk(RW, 0, 32'hFFFF_FFFF, 0, 1, 12'h305, 0, 1, 32'h400, 0, 0));
        vecs.push_back(mk(RW, 0, 32'h400, 0, 1, 12'h305, 0, 1, 32'hFFFF_FFFD, 0, 0));

        // Reset state
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_rdwen", {31'd0, rdwen}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_fpc", flush_pc, 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].imm, vecs[i].rs1, vecs[i].zimm, vecs[i].idx,
                   vecs[i].addr, vecs[i].pc);
            chk($sformatf("v%0d_rdwen", i), {31'd0, g_rdwen}, {31'd0, vecs[i].rdwen});
            chk($sformatf("v%0d_flush", i), {31'd0, g_flush}, {31'd0, vecs[i].flush});
            if (vecs[i].rdwen) chk($sformatf("v%0d_wdata", i), g_wdata, vecs[i].wdata);
            if (vecs[i].flush) chk($sformatf("v%0d_fpc", i), g_fpc, vecs[i].fpc);
        end

        // Vectored interrupt pre-empts a CSR op; lowest enabled line wins
        run_op(RW, 0, 32'h101, 0, 1, 12'h305, 0);
        chk("irq_mtvec_old", g_wdata, 32'h400);
        run_op(RW, 0, 32'h0002_0000, 0, 1, 12'h304, 0);
        irq = 4'b0110;
        rd_csr("irq_mip", 12'h344, 32'h0006_0000);
        run_op(RW, 0, 32'h8, 0, 1, 12'h300, 0);
        chk("irq_mie_set_rdwen", {31'd0, g_rdwen}, 32'd1);
        run_op(RW, 0, 32'h55, 0, 1, 12'h340, 32'h200);
        exp_flush("irq_take", 32'h144);
        irq = 4'b0000;
        rd_csr("irq_mscratch", 12'h340, 32'hE3);
        rd_csr("irq_mepc", 12'h341, 32'h200);
        rd_csr("irq_mcause", 12'h342, 32'h8000_0011);
        rd_csr("irq_mstatus", 12'h300, 32'h80);
        run_op(MR, 0, 0, 0, 0, 12'h000, 0);
        exp_flush("irq_mret", 32'h200);
        rd_csr("mret_mstatus", 12'h300, 32'h88);
        // Exceptions ignore vectored mode
        run_op(EC, 0, 0, 0, 0, 12'h000, 32'h84);
        exp_flush("ecall_vec", 32'h100);
        rd_csr("ecall_mstatus", 12'h300, 32'h80);
        run_op(MR, 0, 0, 0, 0, 12'h000, 0);
        exp_flush("ecall_mret", 32'h84);
        run_op(RW, 0, 32'h0, 0, 1, 12'h300, 0);
        chk("mstatus_after_mret", g_wdata, 32'h88);

        // Counter: a low-half write at all-ones carries into mcycleh next cycle
        run_op(RW, 0, 32'd5, 0, 1, 12'hB80, 0);
        run_op(RW, 0, 32'hFFFF_FFFF, 0, 1, 12'hB00, 0);
        rd_csr("mcycleh_carry", 12'hB80, 32'd6);
        run_op(RW, 0, 32'hFFFF_FFFF, 0, 1, 12'hB00, 0);
        rd_csr("mcycle_wrap", 12'hB00, 32'd0);
        run_op(RW, 0, 32'hFFFF_FFF0, 0, 1, 12'hB00, 0);
        rd_csr("mcycle_count", 12'hB00, 32'hFFFF_FFF1);

        // Reset in the RESP cycle of an ECALL abandons it
        @(negedge clk);
        op = EC; pc = 32'h300; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        chk("rstresp_rdwen", {31'd0, rdwen}, 32'd0);
        chk("rstresp_flush", {31'd0, flush}, 32'd0);
        chk("rstresp_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rstresp_flush2", {31'd0, flush}, 32'd0);
        rd_csr("rstresp_mcause", 12'h342, 32'd0);
        rd_csr("rstresp_mepc", 12'h341, 32'd0);
        rd_csr("rstresp_mtvec", 12'h305, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
